// File: rtl/ras.sv
// Return address stack: circular array of predicted return targets with
// checkpoint outputs and single-cycle repair from execute.
module ras #(
    parameter int unsigned DEPTH    = 8,
    localparam int unsigned PTR_BITS = $clog2(DEPTH),
    localparam int unsigned CNT_BITS = PTR_BITS + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [31:0]         push_addr,
    input  logic                pop,
    output logic                top_valid,
    output logic [31:0]         top_addr,
    output logic [PTR_BITS-1:0] ckpt_sp,
    output logic [CNT_BITS-1:0] ckpt_count,
    output logic [31:0]         ckpt_top,
    input  logic                restore,
    input  logic [PTR_BITS-1:0] restore_sp,
    input  logic [CNT_BITS-1:0] restore_count,
    input  logic [31:0]         restore_top
);

    localparam logic [CNT_BITS-1:0] CountFull = CNT_BITS'(DEPTH);
    localparam logic [PTR_BITS-1:0] PtrOne    = PTR_BITS'(1);

    logic [31:0]         r_entry [DEPTH];
    logic [PTR_BITS-1:0] r_sp;
    logic [CNT_BITS-1:0] r_count;

    logic [PTR_BITS-1:0] w_sp_d;
    logic [CNT_BITS-1:0] w_count_d;
    logic [PTR_BITS-1:0] w_sp_m1;
    logic [PTR_BITS-1:0] w_sp_p1;
    logic                w_empty;
    logic                w_wr_en;
    logic [PTR_BITS-1:0] w_wr_idx;
    logic [31:0]         w_wr_data;

    assign w_sp_m1 = r_sp - PtrOne;
    assign w_sp_p1 = r_sp + PtrOne;
    assign w_empty = (r_count == '0);

    // Reads come straight from current state; no forwarding of same-cycle updates.
    assign top_valid  = !w_empty;
    assign top_addr   = r_entry[w_sp_m1];
    assign ckpt_sp    = r_sp;
    assign ckpt_count = r_count;
    assign ckpt_top   = r_entry[w_sp_m1];

    always_comb begin
        w_sp_d    = r_sp;
        w_count_d = r_count;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_sp;
        w_wr_data = push_addr;
        if (reset) begin
            w_sp_d    = '0;
            w_count_d = '0;
        end else if (restore) begin
            w_sp_d    = restore_sp;
            w_count_d = restore_count;
            w_wr_en   = 1'b1;
            w_wr_idx  = restore_sp - PtrOne;
            w_wr_data = restore_top;
        end else if (push && pop && !w_empty) begin
            // Return immediately followed by a call: replace the top in place.
            w_wr_en  = 1'b1;
            w_wr_idx = w_sp_m1;
        end else if (push) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_sp;
            w_sp_d   = w_sp_p1;
            if (r_count != CountFull) begin
                w_count_d = r_count + CNT_BITS'(1);
            end
        end else if (pop && !w_empty) begin
            w_sp_d    = w_sp_m1;
            w_count_d = r_count - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp    <= '0;
            r_count <= '0;
        end else begin
            r_sp    <= w_sp_d;
            r_count <= w_count_d;
        end
    end

    // Entries are never cleared; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_entry[w_wr_idx] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: a reference model pushes expected state into a
// scoreboard each cycle, plus directed checks of the documented scenarios.
module tb_ras;

    localparam int DEPTH = 8;

    typedef struct {
        logic        valid;
        logic [31:0] top;
        logic [2:0]  sp;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic        top_valid;
    logic [31:0] top_addr;
    logic [2:0]  ckpt_sp;
    logic [3:0]  ckpt_count;
    logic [31:0] ckpt_top;
    logic        restore;
    logic [2:0]  restore_sp;
    logic [3:0]  restore_count;
    logic [31:0] restore_top;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];

    logic [31:0] m_entry [DEPTH];
    int          m_sp;
    int          m_cnt;

    logic [2:0]  cap_sp;
    logic [3:0]  cap_cnt;
    logic [31:0] cap_top;

    always #5 clk = ~clk;

    ras #(.DEPTH(DEPTH)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .push_addr     (push_addr),
        .pop           (pop),
        .top_valid     (top_valid),
        .top_addr      (top_addr),
        .ckpt_sp       (ckpt_sp),
        .ckpt_count    (ckpt_count),
        .ckpt_top      (ckpt_top),
        .restore       (restore),
        .restore_sp    (restore_sp),
        .restore_count (restore_count),
        .restore_top   (restore_top)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare against the scoreboard.
    task automatic step(input logic rst, input logic ps, input logic [31:0] pa,
                        input logic pp, input logic rs, input logic [2:0] rsp,
                        input logic [3:0] rcnt, input logic [31:0] rtop);
        exp_t e;
        exp_t got;
        reset = rst; push = ps; push_addr = pa; pop = pp;
        restore = rs; restore_sp = rsp; restore_count = rcnt; restore_top = rtop;
        if (rst) begin
            m_sp = 0; m_cnt = 0;
        end else if (rs) begin
            m_sp = int'(rsp); m_cnt = int'(rcnt);
            m_entry[(m_sp + DEPTH - 1) % DEPTH] = rtop;
        end else if (ps && pp && m_cnt != 0) begin
            m_entry[(m_sp + DEPTH - 1) % DEPTH] = pa;
        end else if (ps) begin
            m_entry[m_sp] = pa;
            m_sp = (m_sp + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
        end else if (pp && m_cnt != 0) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_cnt--;
        end
        e.valid = (m_cnt != 0);
        e.top   = m_entry[(m_sp + DEPTH - 1) % DEPTH];
        e.sp    = 3'(m_sp);
        e.cnt   = 4'(m_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0; restore = 1'b0;
        got = sb_q.pop_front();
        check("sb_valid", 32'(top_valid), 32'(got.valid));
        check("sb_sp", 32'(ckpt_sp), 32'(got.sp));
        check("sb_count", 32'(ckpt_count), 32'(got.cnt));
        if (got.valid) begin
            check("sb_top", top_addr, got.top);
            check("sb_ckpt_top", ckpt_top, got.top);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 4'd0, 32'h0);
    endtask

    task automatic do_push(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0, 1'b0, 3'd0, 4'd0, 32'h0);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 4'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; push_addr = '0; pop = 1'b0;
        restore = 1'b0; restore_sp = '0; restore_count = '0; restore_top = '0;
        m_sp = 0; m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_entry[i] = '0;

        // Basic push/pop
        do_reset();
        check("rst_valid", 32'(top_valid), 32'd0);
        check("rst_sp", 32'(ckpt_sp), 32'd0);
        check("rst_count", 32'(ckpt_count), 32'd0);
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        check("t1_top", top_addr, 32'h300);
        check("t1_count", 32'(ckpt_count), 32'd3);
        do_pop(); check("t1_pop1", top_addr, 32'h200);
        do_pop(); check("t1_pop2", top_addr, 32'h100);
        do_pop();
        check("t1_empty", 32'(top_valid), 32'd0);
        check("t1_sp", 32'(ckpt_sp), 32'd0);

        // Overflow wraps over the oldest entry
        do_reset();
        for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
        check("t2_count", 32'(ckpt_count), 32'd8);
        check("t2_top", top_addr, 32'h90);
        for (int k = 1; k <= 7; k++) begin
            do_pop();
            check("t2_pop_top", top_addr, 32'(32'h90 - 32'(k * 16)));
        end
        do_pop();
        check("t2_empty", 32'(top_valid), 32'd0);

        // Underflow ignored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_pop();
            check("t3_valid", 32'(top_valid), 32'd0);
            check("t3_sp", 32'(ckpt_sp), 32'd0);
            check("t3_count", 32'(ckpt_count), 32'd0);
        end

        // Push and pop together replace the top
        do_reset();
        do_push(32'h100); do_push(32'h200);
        step(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 3'd0, 4'd0, 32'h0);
        check("t4_count", 32'(ckpt_count), 32'd2);
        check("t4_top", top_addr, 32'h500);
        do_pop();
        check("t4_below", top_addr, 32'h100);

        // Checkpoint and restore; same-cycle push is dropped
        do_reset();
        do_push(32'h100); do_push(32'h200);
        cap_sp = ckpt_sp; cap_cnt = ckpt_count; cap_top = ckpt_top;
        check("t5_cap_sp", 32'(cap_sp), 32'd2);
        check("t5_cap_cnt", 32'(cap_cnt), 32'd2);
        check("t5_cap_top", cap_top, 32'h200);
        do_pop(); do_push(32'hAAA); do_push(32'hBBB);
        step(1'b0, 1'b1, 32'hCCC, 1'b0, 1'b1, cap_sp, cap_cnt, cap_top);
        check("t5_top", top_addr, 32'h200);
        check("t5_count", 32'(ckpt_count), 32'd2);
        check("t5_sp", 32'(ckpt_sp), 32'd2);

        // Reset wins over a same-cycle push
        do_push(32'h700);
        step(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 3'd0, 4'd0, 32'h0);
        check("t6_count", 32'(ckpt_count), 32'd0);
        check("t6_sp", 32'(ckpt_sp), 32'd0);
        check("t6_valid", 32'(top_valid), 32'd0);

        // Mixed random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            step(r[7:0] == 8'd0, r[8], {r[31:12], 12'h0} | 32'(i), r[9],
                 r[11:10] == 2'b11, 3'(r[14:12]), 4'(r[17:15] + 3'd1), 32'(i) ^ 32'hF00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
